// File: rtl/apple_pkg.sv
// Shared constants and state encoding for apple placement.
package apple_pkg;

  localparam int COORD_W = 11;

  localparam logic [COORD_W-1:0] MIN_X   = 11'd16;
  localparam logic [COORD_W-1:0] MAX_X   = 11'd1392;
  localparam logic [COORD_W-1:0] MIN_Y   = 11'd16;
  localparam logic [COORD_W-1:0] MAX_Y   = 11'd848;
  localparam logic [COORD_W-1:0] RESET_X = 11'd48;
  localparam logic [COORD_W-1:0] RESET_Y = 11'd16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SAMPLE = 3'd1,
    SCAN   = 3'd2,
    COMMIT = 3'd3,
    FAIL   = 3'd4
  } spawn_state_t;

endpackage

// File: rtl/apple_pos_check.sv
// Combinational reject for a food candidate: outside the play field, on the wall
// block, or on the snake head.
module apple_pos_check
  import apple_pkg::*;
(
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic [COORD_W-1:0] wall_x,
  input  logic [COORD_W-1:0] wall_y,
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  output logic               reject
);

  logic out_of_bounds;
  logic on_wall;
  logic on_head;

  assign out_of_bounds = (x < MIN_X) || (x > MAX_X) || (y < MIN_Y) || (y > MAX_Y);
  assign on_wall       = (x == wall_x) && (y == wall_y);
  assign on_head       = (x == head_x) && (y == head_y);
  assign reject        = out_of_bounds || on_wall || on_head;

endmodule

// File: rtl/apple_spawn_ctrl.sv
// Apple placement sequencer: samples candidates on eat, rejects illegal spots and
// scans the snake body store before publishing a new apple position.
module apple_spawn_ctrl
  import apple_pkg::*;
#(
  parameter int MAX_LEN   = 64,
  parameter int IDX_W     = 6,
  parameter int MAX_TRIES = 16
) (
  input  logic               clk,
  input  logic               btnrst_n,
  input  logic               eat,
  input  logic [COORD_W-1:0] cand_x,
  input  logic [COORD_W-1:0] cand_y,
  input  logic [COORD_W-1:0] snakehead_x,
  input  logic [COORD_W-1:0] snakehead_y,
  input  logic [COORD_W-1:0] wallpos_x,
  input  logic [COORD_W-1:0] wallpos_y,
  input  logic [IDX_W:0]     body_len,
  output logic [IDX_W-1:0]   body_rd_idx,
  input  logic [COORD_W-1:0] body_rd_x,
  input  logic [COORD_W-1:0] body_rd_y,
  output logic [COORD_W-1:0] apple_x,
  output logic [COORD_W-1:0] apple_y,
  output logic               apple_valid,
  output logic               busy,
  output logic               spawn_done,
  output logic               spawn_fail
);

  localparam int                 TRY_W     = $clog2(MAX_TRIES + 1);
  localparam logic [TRY_W-1:0]   TRY_LIMIT = TRY_W'(MAX_TRIES);
  localparam logic [IDX_W:0]     LEN_MAX   = (IDX_W + 1)'(MAX_LEN);

  spawn_state_t       state;
  logic [TRY_W-1:0]   tries;
  logic [TRY_W-1:0]   tries_next;
  logic               pending;
  logic [COORD_W-1:0] cand_rx;
  logic [COORD_W-1:0] cand_ry;
  logic [IDX_W:0]     scan_len;
  logic [IDX_W:0]     scan_cnt;
  logic               cand_reject;
  logic               seg_hit;

  apple_pos_check u_pos_check (
    .x      (cand_x),
    .y      (cand_y),
    .wall_x (wallpos_x),
    .wall_y (wallpos_y),
    .head_x (snakehead_x),
    .head_y (snakehead_y),
    .reject (cand_reject)
  );

  assign tries_next = tries + 1'b1;
  assign busy       = (state != IDLE);

  // Read data lags the index by one cycle, so the first SCAN cycle has nothing to compare.
  assign seg_hit = (scan_cnt != '0) && (body_rd_x == cand_rx) && (body_rd_y == cand_ry);

  always_ff @(posedge clk or negedge btnrst_n) begin
    if (!btnrst_n) begin
      state       <= IDLE;
      tries       <= '0;
      pending     <= 1'b0;
      cand_rx     <= '0;
      cand_ry     <= '0;
      scan_len    <= '0;
      scan_cnt    <= '0;
      body_rd_idx <= '0;
      apple_x     <= RESET_X;
      apple_y     <= RESET_Y;
      apple_valid <= 1'b1;
      spawn_done  <= 1'b0;
      spawn_fail  <= 1'b0;
    end else begin
      spawn_done <= 1'b0;
      spawn_fail <= 1'b0;
      if (busy && eat)
        pending <= 1'b1;

      case (state)
        IDLE: begin
          if (eat) begin
            state       <= SAMPLE;
            tries       <= '0;
            apple_valid <= 1'b0;
          end
        end

        SAMPLE: begin
          cand_rx <= cand_x;
          cand_ry <= cand_y;
          tries   <= tries_next;
          if (cand_reject) begin
            if (tries_next == TRY_LIMIT) begin
              state      <= FAIL;
              spawn_fail <= 1'b1;
            end
          end else if (body_len == '0) begin
            state       <= COMMIT;
            apple_x     <= cand_x;
            apple_y     <= cand_y;
            apple_valid <= 1'b1;
            spawn_done  <= 1'b1;
          end else begin
            state       <= SCAN;
            scan_len    <= (body_len > LEN_MAX) ? LEN_MAX : body_len;
            scan_cnt    <= '0;
            body_rd_idx <= '0;
          end
        end

        SCAN: begin
          if (seg_hit) begin
            if (tries == TRY_LIMIT) begin
              state      <= FAIL;
              spawn_fail <= 1'b1;
            end else begin
              state <= SAMPLE;
            end
          end else if (scan_cnt == scan_len) begin
            state       <= COMMIT;
            apple_x     <= cand_rx;
            apple_y     <= cand_ry;
            apple_valid <= 1'b1;
            spawn_done  <= 1'b1;
          end else begin
            scan_cnt    <= scan_cnt + 1'b1;
            body_rd_idx <= scan_cnt[IDX_W-1:0] + 1'b1;
          end
        end

        // An eat arriving in this last cycle is treated like a pending one.
        COMMIT, FAIL: begin
          if (pending || eat) begin
            state       <= SAMPLE;
            tries       <= '0;
            pending     <= 1'b0;
            apple_valid <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
